img_stream_gen: RTL

- Video stream source that drives the pre_img_vsync / pre_img_hsync / pre_img_valid / pre_img_data interface consumed by the image-processing chain (3x3 window generator, sobel detector).
- Generates raster timing from parameterised porches and sync widths.
- Pulls pixels from an upstream valid/ready source, typically a frame-buffer read FIFO.
- Flags underflow when the source cannot keep up.

---
 rtl/img_pkg.sv | 26 ++
 rtl/img_timing_cnt.sv | 58 +++++
 rtl/img_stream_gen.sv | 108 ++++++++++
 3 files changed

// File: rtl/img_pkg.sv
// Shared types and timing presets for the image stream source.
// Holds the default pixel width, standard raster timings and the source FSM states.
package img_pkg;

    localparam int DW_DEF = 8;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } timing_t;

    localparam timing_t T_640X480  = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam timing_t T_1280X720 = '{1280, 110, 40, 220, 720, 5, 5, 20};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/img_timing_cnt.sv
// Raster h/v counters with combinational region decode (act/hs/vs, frame origin, last-of-frame).
// Zero latency decode; counters free-run while run is high and sit at 0 otherwise, never stalled.
module img_timing_cnt #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic act,
    output logic hs,
    output logic vs,
    output logic first,
    output logic last
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_last;
    logic          v_last;

    assign h_last = (32'(h_cnt) == H_TOTAL - 1);
    assign v_last = (32'(v_cnt) == V_TOTAL - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // vsync covers whole lines, so it only looks at v_cnt
    assign act   = run && (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
    assign hs    = run && (32'(h_cnt) >= H_ACTIVE + H_FP) && (32'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
    assign vs    = run && (32'(v_cnt) >= V_ACTIVE + V_FP) && (32'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);
    assign first = run && (h_cnt == '0) && (v_cnt == '0);
    assign last  = run && h_last && v_last;

endmodule

// File: rtl/img_stream_gen.sv
// Video stream source: raster timing plus pixels pulled from a valid/ready upstream.
// One register stage to img_*; pix_ready is pure raster (never waits on pix_valid), gaps become 0-data slots and set sticky underflow.
module img_stream_gen
    import img_pkg::*;
#(
    parameter int H_ACTIVE = T_640X480.h_active,
    parameter int H_FP     = T_640X480.h_fp,
    parameter int H_SYNC   = T_640X480.h_sync,
    parameter int H_BP     = T_640X480.h_bp,
    parameter int V_ACTIVE = T_640X480.v_active,
    parameter int V_FP     = T_640X480.v_fp,
    parameter int V_SYNC   = T_640X480.v_sync,
    parameter int V_BP     = T_640X480.v_bp,
    parameter int DW       = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          pix_valid,
    input  logic [DW-1:0] pix_data,
    output logic          pix_ready,
    output logic          img_vsync,
    output logic          img_hsync,
    output logic          img_valid,
    output logic [DW-1:0] img_data,
    output logic          frame_start,
    output logic          underflow,
    input  logic          underflow_clr
);

    state_e state;
    state_e state_nx;
    logic   run;
    logic   act;
    logic   hs;
    logic   vs;
    logic   first;
    logic   last;
    logic   uf_set;

    img_timing_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .act   (act),
        .hs    (hs),
        .vs    (vs),
        .first (first),
        .last  (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // en only matters at the frame boundary so a frame is never cut short
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (en) state_nx = ST_RUN;
            ST_RUN:  if (last && !en) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        run = (state == ST_RUN);
    end

    assign pix_ready = act;
    assign uf_set    = act && !pix_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            img_vsync   <= 1'b0;
            img_hsync   <= 1'b0;
            img_valid   <= 1'b0;
            img_data    <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            img_vsync   <= vs;
            img_hsync   <= hs;
            img_valid   <= act;
            img_data    <= (act && pix_valid) ? pix_data : '0;
            frame_start <= act && first;
            if (uf_set) begin
                underflow <= 1'b1;
            end else if (underflow_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule
